// File: rtl/issue_sched_if.sv
// Dispatch/issue bundle between the reservation station and the issue scheduler.
// The master drives allocations, entry status and FU readiness; the slave returns picks.
interface issue_sched_if #(
  parameter int NUM_ENTRIES = 8,
  parameter int IDX_W       = 3
);
  logic [1:0]             alloc_we;
  logic [IDX_W-1:0]       alloc_idx0;
  logic [IDX_W-1:0]       alloc_idx1;
  logic [NUM_ENTRIES-1:0] entry_valid;
  logic [NUM_ENTRIES-1:0] entry_rdy;
  logic [1:0]             fu_rdy;
  logic [1:0]             issue_vld;
  logic [IDX_W-1:0]       issue_idx0;
  logic [IDX_W-1:0]       issue_idx1;
  logic [1:0]             issue_fire;
  logic                   alloc_err;

  modport master (
    output alloc_we, alloc_idx0, alloc_idx1, entry_valid, entry_rdy, fu_rdy,
    input  issue_vld, issue_idx0, issue_idx1, issue_fire, alloc_err
  );

  modport slave (
    input  alloc_we, alloc_idx0, alloc_idx1, entry_valid, entry_rdy, fu_rdy,
    output issue_vld, issue_idx0, issue_idx1, issue_fire, alloc_err
  );
endinterface

// File: rtl/issue_sched.sv
// Two-port oldest-first issue scheduler built on an age matrix.
// Picks are registered per port and held until the port's functional unit accepts.
module issue_sched #(
  parameter int NUM_ENTRIES = 8,
  parameter int IDX_W       = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  issue_sched_if.slave bus
);
  localparam int N = NUM_ENTRIES;

  logic [N-1:0]     r_age [N];
  logic [1:0]       r_vld;
  logic [IDX_W-1:0] r_idx0;
  logic [IDX_W-1:0] r_idx1;
  logic             r_err;

  logic [1:0]          w_fire;
  logic [1:0]          w_load;
  logic [N-1:0]        w_hit0;
  logic [N-1:0]        w_hit1;
  logic [N-1:0]        w_held;
  logic [N-1:0]        w_elig;
  logic [N-1:0]        w_elig2;
  logic [N-1:0]        w_first;
  logic [N-1:0]        w_second;
  logic [N-1:0]        w_first_oh;
  logic [IDX_W-1:0]    w_first_idx;
  logic [IDX_W-1:0]    w_second_idx;
  logic                w_first_any;
  logic                w_second_any;
  logic                w_bad;
  logic [N-1:0][N-1:0] w_age_next;

  assign w_fire = r_vld & bus.fu_rdy;
  assign w_load = ~r_vld | w_fire;

  genvar gi, gj;
  generate
    for (gi = 0; gi < N; gi++) begin : g_entry
      localparam logic [N-1:0] SELF = N'(1) << gi;
      assign w_hit0[gi] = bus.alloc_we[0] && (bus.alloc_idx0 == IDX_W'(gi));
      assign w_hit1[gi] = bus.alloc_we[1] && (bus.alloc_idx1 == IDX_W'(gi));
      assign w_held[gi] = (r_vld[0] && (r_idx0 == IDX_W'(gi))) ||
                          (r_vld[1] && (r_idx1 == IDX_W'(gi)));
      // Held entries (firing ones included) and this cycle's allocations never compete.
      assign w_elig[gi] = bus.entry_valid[gi] && bus.entry_rdy[gi] && !w_held[gi] &&
                          !w_hit0[gi] && !w_hit1[gi];
      assign w_first[gi]  = w_elig[gi]  && ((w_elig  & ~r_age[gi] & ~SELF) == '0);
      assign w_second[gi] = w_elig2[gi] && ((w_elig2 & ~r_age[gi] & ~SELF) == '0);

      for (gj = 0; gj < N; gj++) begin : g_col
        // Slot1's row is cleared last; slot0's row keeps only the bit for slot1's entry.
        assign w_age_next[gi][gj] = w_hit1[gi] ? 1'b0 :
                                    w_hit0[gi] ? w_hit1[gj] :
                                    (w_hit0[gj] || w_hit1[gj]) ? bus.entry_valid[gi] :
                                    r_age[gi][gj];
      end
    end
  endgenerate

  always_comb begin
    w_first_idx = '0;
    w_first_oh  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_first[i]) begin
        w_first_idx   = IDX_W'(i);
        w_first_oh    = '0;
        w_first_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    w_second_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_second[i]) w_second_idx = IDX_W'(i);
    end
  end

  assign w_first_any  = |w_first;
  assign w_second_any = |w_second;
  assign w_elig2      = w_elig & ~w_first_oh;

  assign w_bad = (bus.alloc_we[0] && bus.entry_valid[bus.alloc_idx0]) ||
                 (bus.alloc_we[1] && bus.entry_valid[bus.alloc_idx1]) ||
                 ((&bus.alloc_we) && (bus.alloc_idx0 == bus.alloc_idx1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) r_age[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < N; i++) r_age[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) r_age[i] <= w_age_next[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld  <= 2'b00;
      r_idx0 <= '0;
      r_idx1 <= '0;
    end else if (flush) begin
      r_vld  <= 2'b00;
      r_idx0 <= '0;
      r_idx1 <= '0;
    end else begin
      if (w_load[0]) begin
        r_vld[0] <= w_first_any;
        r_idx0   <= w_first_idx;
      end
      // Port1 only gets the runner-up when port0 is also taking a pick.
      if (w_load[1]) begin
        if (w_load[0]) begin
          r_vld[1] <= w_second_any;
          r_idx1   <= w_second_idx;
        end else begin
          r_vld[1] <= w_first_any;
          r_idx1   <= w_first_idx;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (w_bad) begin
      r_err <= 1'b1;
    end
  end

  assign bus.issue_vld  = r_vld;
  assign bus.issue_idx0 = r_idx0;
  assign bus.issue_idx1 = r_idx1;
  assign bus.issue_fire = w_fire;
  assign bus.alloc_err  = r_err;
endmodule

// File: tb/tb_issue_sched.sv
// Bench for issue_sched: directed scenarios then random traffic, checked against
// a sequence-number model of the reservation station (oldest = smallest alloc number).
module tb_issue_sched;
  localparam int N  = 8;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  issue_sched_if #(.NUM_ENTRIES(N), .IDX_W(IW)) bus ();

  issue_sched #(.NUM_ENTRIES(N), .IDX_W(IW)) dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .bus  (bus)
  );

  bit          m_valid [N];
  int unsigned m_seq   [N];
  int unsigned m_cnt;
  bit          m_hv    [2];
  int          m_hidx  [2];
  bit          m_err;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_seq[i]   = 0;
    end
    m_hv[0] = 1'b0; m_hv[1] = 1'b0;
    m_hidx[0] = 0;  m_hidx[1] = 0;
    m_err = 1'b0;
    m_cnt = 0;
  endtask

  task automatic set_port(input int p, input int x);
    m_hv[p] = (x >= 0);
    if (x >= 0) m_hidx[p] = x;
  endtask

  // One clock cycle: drive at the falling edge, check registered outputs, advance the model.
  task automatic step(input logic [1:0] we, input int k0, input int k1,
                      input logic [N-1:0] rdy, input logic [1:0] fu, input bit fl);
    logic [N-1:0] v;
    logic [1:0]   fire;
    logic [1:0]   load;
    int           first;
    int           second;
    bit           held;
    for (int i = 0; i < N; i++) v[i] = m_valid[i];
    bus.alloc_we    = we;
    bus.alloc_idx0  = IW'(k0);
    bus.alloc_idx1  = IW'(k1);
    bus.entry_valid = v;
    bus.entry_rdy   = rdy;
    bus.fu_rdy      = fu;
    flush           = fl;
    #1;
    fire = {m_hv[1] & fu[1], m_hv[0] & fu[0]};
    chk("issue_vld", 32'(bus.issue_vld), 32'({m_hv[1], m_hv[0]}));
    if (m_hv[0]) chk("issue_idx0", 32'(bus.issue_idx0), 32'(m_hidx[0]));
    if (m_hv[1]) chk("issue_idx1", 32'(bus.issue_idx1), 32'(m_hidx[1]));
    chk("issue_fire", 32'(bus.issue_fire), 32'(fire));
    chk("alloc_err", 32'(bus.alloc_err), 32'(m_err));
    $display("t=%0t we=%b k0=%0d k1=%0d val=%b rdy=%b fu=%b fl=%0d | vld=%b idx0=%0d idx1=%0d fire=%b err=%b",
             $time, we, k0, k1, v, rdy, fu, fl, bus.issue_vld, bus.issue_idx0,
             bus.issue_idx1, bus.issue_fire, bus.alloc_err);

    if ((we[0] && m_valid[k0]) || (we[1] && m_valid[k1]) || (we == 2'b11 && k0 == k1))
      m_err = 1'b1;
    if (fl) begin
      m_hv[0] = 1'b0; m_hv[1] = 1'b0;
      for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    end else begin
      first = -1; second = -1;
      for (int i = 0; i < N; i++) begin
        held = (m_hv[0] && m_hidx[0] == i) || (m_hv[1] && m_hidx[1] == i);
        if (m_valid[i] && rdy[i] && !held && !(we[0] && k0 == i) && !(we[1] && k1 == i)) begin
          if (first < 0 || m_seq[i] < m_seq[first]) begin
            second = first;
            first  = i;
          end else if (second < 0 || m_seq[i] < m_seq[second]) begin
            second = i;
          end
        end
      end
      load = {!m_hv[1] || fire[1], !m_hv[0] || fire[0]};
      for (int p = 0; p < 2; p++) if (fire[p]) m_valid[m_hidx[p]] = 1'b0;
      if (load[0] && load[1]) begin
        set_port(0, first);
        set_port(1, second);
      end else if (load[0]) begin
        set_port(0, first);
      end else if (load[1]) begin
        set_port(1, first);
      end
      if (we[0]) begin m_valid[k0] = 1'b1; m_seq[k0] = m_cnt; m_cnt++; end
      if (we[1]) begin m_valid[k1] = 1'b1; m_seq[k1] = m_cnt; m_cnt++; end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cleanup();
    step(2'b00, 0, 0, '0, 2'b00, 1'b1);
    step(2'b00, 0, 0, '0, 2'b00, 1'b0);
  endtask

  initial begin
    logic [1:0] rwe;
    int         rk0;
    int         rk1;
    int         a;
    int         fr[$];

    model_reset();
    bus.alloc_we = '0; bus.alloc_idx0 = '0; bus.alloc_idx1 = '0;
    bus.entry_valid = '0; bus.entry_rdy = '0; bus.fu_rdy = 2'b11;
    #3;
    chk("rst_vld", 32'(bus.issue_vld), 32'd0);
    chk("rst_idx0", 32'(bus.issue_idx0), 32'd0);
    chk("rst_idx1", 32'(bus.issue_idx1), 32'd0);
    chk("rst_fire", 32'(bus.issue_fire), 32'd0);
    chk("rst_err", 32'(bus.alloc_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Single allocs 2, 5, 1: first two pair up, then 1 issues alone.
    step(2'b01, 2, 0, '1, 2'b00, 1'b0);
    step(2'b01, 5, 0, '1, 2'b00, 1'b0);
    step(2'b01, 1, 0, '1, 2'b00, 1'b0);
    chk("seq_vld", 32'(bus.issue_vld), 32'd3);
    chk("seq_idx0", 32'(bus.issue_idx0), 32'd2);
    chk("seq_idx1", 32'(bus.issue_idx1), 32'd5);
    step(2'b00, 0, 0, '1, 2'b11, 1'b0);
    chk("seq2_vld", 32'(bus.issue_vld), 32'd1);
    chk("seq2_idx0", 32'(bus.issue_idx0), 32'd1);
    cleanup();

    // Port0 stalled on 3 while older 6 becomes ready and lands on port1.
    step(2'b01, 6, 0, '0, 2'b00, 1'b0);
    step(2'b01, 3, 0, '0, 2'b00, 1'b0);
    step(2'b00, 0, 0, N'(1) << 3, 2'b00, 1'b0);
    for (int c = 0; c < 4; c++) begin
      step(2'b00, 0, 0, (N'(1) << 3) | (N'(1) << 6), 2'b00, 1'b0);
      chk("stall_idx0", 32'(bus.issue_idx0), 32'd3);
      chk("stall_fire", 32'(bus.issue_fire), 32'd0);
    end
    chk("stall_idx1", 32'(bus.issue_idx1), 32'd6);
    chk("stall_vld", 32'(bus.issue_vld), 32'd3);
    bus.fu_rdy = 2'b01;
    #1;
    chk("stall_fire01", 32'(bus.issue_fire), 32'd1);
    cleanup();

    // Dual alloc: slot0 entry is older.
    step(2'b11, 4, 0, '0, 2'b00, 1'b0);
    step(2'b00, 0, 0, '1, 2'b00, 1'b0);
    chk("dual_idx0", 32'(bus.issue_idx0), 32'd4);
    chk("dual_idx1", 32'(bus.issue_idx1), 32'd0);
    cleanup();

    // Flush beats simultaneous allocs and full ports.
    step(2'b11, 2, 3, '0, 2'b00, 1'b0);
    step(2'b00, 0, 0, '1, 2'b00, 1'b0);
    step(2'b11, 5, 6, '1, 2'b00, 1'b1);
    chk("flush_vld", 32'(bus.issue_vld), 32'd0);
    step(2'b01, 6, 0, '0, 2'b00, 1'b0);
    step(2'b01, 5, 0, '0, 2'b00, 1'b0);
    step(2'b00, 0, 0, '1, 2'b00, 1'b0);
    chk("postflush_idx0", 32'(bus.issue_idx0), 32'd6);
    chk("postflush_idx1", 32'(bus.issue_idx1), 32'd5);
    cleanup();

    // Illegal re-alloc of a live entry sets the sticky error, which survives flush.
    step(2'b01, 7, 0, '0, 2'b00, 1'b0);
    step(2'b01, 7, 0, '0, 2'b00, 1'b0);
    chk("err_set", 32'(bus.alloc_err), 32'd1);
    cleanup();
    chk("err_sticky", 32'(bus.alloc_err), 32'd1);

    // Asynchronous reset while port1 is stalled.
    step(2'b11, 1, 2, '0, 2'b00, 1'b0);
    step(2'b00, 0, 0, '1, 2'b00, 1'b0);
    step(2'b00, 0, 0, '1, 2'b01, 1'b0);
    chk("pre_rst_vld", 32'(bus.issue_vld), 32'd2);
    bus.fu_rdy = 2'b11;
    #1;
    chk("pre_rst_fire", 32'(bus.issue_fire), 32'd2);
    rst = 1'b0;
    #1;
    chk("arst_vld", 32'(bus.issue_vld), 32'd0);
    chk("arst_idx0", 32'(bus.issue_idx0), 32'd0);
    chk("arst_idx1", 32'(bus.issue_idx1), 32'd0);
    chk("arst_fire", 32'(bus.issue_fire), 32'd0);
    chk("arst_err", 32'(bus.alloc_err), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // Random legal traffic.
    for (int c = 0; c < 300; c++) begin
      fr.delete();
      for (int i = 0; i < N; i++) if (!m_valid[i]) fr.push_back(i);
      rwe = 2'b00; rk0 = 0; rk1 = 0;
      if (fr.size() > 0 && $urandom_range(0, 2) != 0) begin
        a = $urandom_range(0, fr.size() - 1);
        rk0 = fr[a]; fr.delete(a); rwe[0] = 1'b1;
      end
      if (fr.size() > 0 && $urandom_range(0, 2) == 0) begin
        a = $urandom_range(0, fr.size() - 1);
        rk1 = fr[a]; fr.delete(a); rwe[1] = 1'b1;
      end
      step(rwe, rk0, rk1, N'($urandom), 2'($urandom), ($urandom_range(0, 39) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/issue_sched.md
ISSUE_SCHED -- requirements
Module: issue_sched

Interface
REQ-001 The block SHALL have parameter NUM_ENTRIES, default 8, meaning number of reservation-station entries scheduled.
REQ-002 The block SHALL have parameter IDX_W, default 3, meaning entry index width, equal to clog2(NUM_ENTRIES).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port flush, input, 1, synchronous pipeline flush.
REQ-006 The block SHALL have port alloc_we, input, 2, dispatch writes this cycle; slot0 is older than slot1.
REQ-007 The block SHALL have ports alloc_idx0 and alloc_idx1, input, IDX_W each, RS entry written by each slot.
REQ-008 The block SHALL have port entry_valid, input, NUM_ENTRIES, RS entry occupied.
REQ-009 The block SHALL have port entry_rdy, input, NUM_ENTRIES, all source operands of the entry available.
REQ-010 The block SHALL have port fu_rdy, input, 2, issue port p's functional unit accepts this cycle.
REQ-011 The block SHALL have port issue_vld, output, 2, issue port p holds a selected entry.
REQ-012 The block SHALL have ports issue_idx0 and issue_idx1, output, IDX_W each, entry held by each port.
REQ-013 The block SHALL have port issue_fire, output, 2, issue_vld[p] AND fu_rdy[p]; RS frees that entry.
REQ-014 The block SHALL have port alloc_err, output, 1, sticky flag for an illegal allocation.

Function
REQ-015 The block SHALL keep an NUM_ENTRIES x NUM_ENTRIES age matrix; age[i][j]=1 means entry i is older than entry j.
REQ-016 On alloc of entry k, the block SHALL clear row k and set column k for every entry valid that cycle, so k is youngest.
REQ-017 On dual alloc, the block SHALL make alloc_idx0 older than alloc_idx1.
REQ-018 An entry SHALL be eligible when entry_valid=1, entry_rdy=1, it is not held in a port register, and it is not firing this cycle.
REQ-019 The oldest eligible entry SHALL be the one whose age-row covers every other eligible entry.
REQ-020 Each port register SHALL load a new pick when it is empty or firing; otherwise it SHALL hold idx and vld unchanged.
REQ-021 If both ports load, port0 SHALL take the oldest eligible entry and port1 the second-oldest.
REQ-022 If only one port loads, that port SHALL take the oldest eligible entry.
REQ-023 If no entry is eligible for a loading port, that port's issue_vld SHALL become 0.
REQ-024 Latency SHALL be one cycle: an entry eligible in cycle t appears on issue_* in cycle t+1.
REQ-025 A held entry SHALL stay held even if entry_rdy later drops, because operands are already captured.
REQ-026 Entries allocated in cycle t SHALL NOT be eligible before cycle t+1.
REQ-027 alloc_err SHALL set when alloc_we targets an index with entry_valid=1, or when both slots name the same index.
REQ-028 The faulting alloc SHALL still update the age matrix.
REQ-029 When flush=1, the block SHALL clear issue_vld, the age matrix and issue_fire's registered sources at the next edge.
REQ-030 flush SHALL take priority over alloc and load in the same cycle.
REQ-031 flush SHALL NOT clear alloc_err.
REQ-032 issue_fire SHALL be combinational from registered issue_vld and fu_rdy.

Reset
REQ-033 While rst=0, issue_vld=00, issue_idx0=issue_idx1=0, issue_fire=00, alloc_err=0, and the age matrix SHALL be all zero.
REQ-034 Reset SHALL take effect immediately, mid-handshake included, and held entries SHALL be discarded.
REQ-035 After rst deasserts, the first loads SHALL occur on the first rising edge.

Verification
REQ-036 Allocate 2, then 5, then 1 (one per cycle), all ready -> issue_idx0=2 and issue_idx1=5 next cycle; with both fu_rdy=1, the following cycle gives issue_idx0=1 and issue_vld=01.
REQ-037 Entry 3 held on port0 with fu_rdy[0]=0 for 4 cycles while older entry 6 becomes ready -> idx0 stays 3, port1 shows 6, and issue_fire=00 until fu_rdy.
REQ-038 Dual alloc idx0=4, idx1=0, both ready -> port0=4 and port1=0.
REQ-039 flush while both ports are valid and alloc_we=11 -> issue_vld=00 next cycle; the new allocs do not appear as older than later allocs.
REQ-040 Alloc to a valid index 7 -> alloc_err=1 and stays 1 through flush; rst=0 clears it asynchronously.
REQ-041 Assert rst=0 mid-cycle while port1 is stalled -> all outputs are 0 before the next edge.
